// File: rtl/uart_host_tx_pkg.sv
// Shared definitions for the host-side UART transmitter: FSM state
// encoding, 8N1 frame constants and the baud divisor calculation.
package uart_host_tx_pkg;

    // Two-bit transmitter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // 8N1 frame constants.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Clocks per serial bit, truncated toward zero.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmitter. Pointers carry one extra wrap
// bit so full and empty come straight from the pointer comparison.
// Both flags are registered and describe the occupancy after each edge.
module uart_tx_fifo #(
    parameter int depth = 8,
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] wr_data,
    input  logic             pop,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_next;
    logic [AW:0]      rd_ptr_next;
    logic             full_next;
    logic             empty_next;
    logic             push_ok;
    logic             pop_ok;
    logic [width-1:0] mem [depth];

    // A push into a full FIFO or a pop from an empty one is ignored,
    // judged against the flags as they stand before this edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer advance and the resulting flags for the coming edge.
    always_comb begin
        wr_ptr_next = push_ok ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_next = pop_ok  ? rd_ptr + 1'b1 : rd_ptr;
        full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
        empty_next  = (wr_ptr_next == rd_ptr_next);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            full   <= full_next;
            empty  <= empty_next;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_host_tx.sv
// Host UART transmitter: byte FIFO feeding an 8N1 serialiser.
//
// Write interface: tx_wr is a single-cycle strobe with no back-pressure.
// tx_data is taken on any edge where tx_wr = 1 and tx_full = 0; a strobe
// while tx_full = 1 is dropped and latches tx_overflow until reset.
//
// The line register follows the FSM one clock behind, so every bit is
// exactly DIV clocks wide and frames from a non-empty FIFO run back to
// back with no idle clock between the stop bit and the next start bit.
module uart_host_tx
    import uart_host_tx_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 1152000,
    parameter int fifo_depth     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       uart_txd,
    output tx_state_t  state_dbg
);

    localparam int DIV = calc_div(clk_freq, uart_baud_rate);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_host_tx: clk_freq / uart_baud_rate must be at least 2");
    end
    if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
        $error("uart_host_tx: fifo_depth must be a power of two and at least 2");
    end

    tx_state_t state;
    tx_state_t state_next;

    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          baud_done;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic          txd_q;
    logic          busy_q;
    logic          overflow_q;

    uart_tx_fifo #(
        .depth (fifo_depth),
        .width (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_wr),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign baud_done = (baud_cnt == CW'(DIV - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a pop happens on every entry into START.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_START;
                    fifo_pop   = 1'b1;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done && (bit_cnt == 3'(DATA_BITS - 1))) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        state_next = ST_START;
                        fifo_pop   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Baud counter, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if ((state == ST_IDLE) || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if ((state == ST_DATA) && baud_done) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
            if (fifo_pop) begin
                bit_cnt   <= '0;
                shift_reg <= fifo_rd_data;
            end
        end
    end

    // Line register, one clock behind the state it encodes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            txd_q <= STOP_BIT;
        end else begin
            case (state)
                ST_START: txd_q <= START_BIT;
                ST_DATA:  txd_q <= shift_reg[0];
                default:  txd_q <= STOP_BIT;
            endcase
        end
    end

    // Busy covers the lagged stop bit and any byte still queued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state != ST_IDLE) || !fifo_empty || (tx_wr && !fifo_full);
        end
    end

    // Sticky overflow on a write that meets a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (tx_wr && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign uart_txd    = txd_q;
    assign tx_full     = fifo_full;
    assign tx_busy     = busy_q;
    assign tx_overflow = overflow_q;
    assign state_dbg   = state;

endmodule
